// File: rtl/data_if.sv
// Instruction-fetch stage of the pipelined LEGv8 core: owns the PC, drives the
// instruction-memory address and loads the IF/ID pipeline register.
module data_if #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        BRsignal,
    input  logic [63:0] BR_to_shift,
    input  logic [63:0] pc_id,
    input  logic [31:0] instr_mem,
    output logic [63:0] imem_addr,
    output logic [63:0] pc_if,
    output logic [31:0] instr_if,
    output logic [63:0] BLT,
    output logic        valid_if,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_REDIRECT,
        ACT_ADVANCE
    } action_e;

    action_e     action;
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [63:0] pc_plus4;
    logic [63:0] br_target;

    logic [63:0] pc_if_d;
    logic [31:0] instr_if_d;
    logic [63:0] blt_d;
    logic        valid_if_d;
    logic [31:0] fetch_count_d;

    // Stall outranks a branch: the branching instruction is held in decode
    // and will present its redirect again once the stall lifts.
    always_comb begin
        if (stall)
            action = ACT_HOLD;
        else if (BRsignal)
            action = ACT_REDIRECT;
        else
            action = ACT_ADVANCE;
    end

    // Shift and adds are plain 64-bit modulo arithmetic; carries fall off the top.
    assign br_target = pc_id + (BR_to_shift << 2);
    assign pc_plus4  = pc_q + 64'd4;
    assign imem_addr = pc_q;

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_d          = pc_q;
        pc_if_d       = pc_if;
        instr_if_d    = instr_if;
        blt_d         = BLT;
        valid_if_d    = valid_if;
        fetch_count_d = fetch_count;
        case (action)
            ACT_REDIRECT: begin
                pc_d       = br_target;
                instr_if_d = NOP_INSTR;
                valid_if_d = 1'b0;
            end
            ACT_ADVANCE: begin
                pc_d          = pc_plus4;
                pc_if_d       = pc_q;
                instr_if_d    = instr_mem;
                blt_d         = pc_plus4;
                valid_if_d    = 1'b1;
                fetch_count_d = fetch_count + 32'd1;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            pc_if       <= 64'h0;
            instr_if    <= NOP_INSTR;
            BLT         <= 64'h0;
            valid_if    <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            pc_if       <= pc_if_d;
            instr_if    <= instr_if_d;
            BLT         <= blt_d;
            valid_if    <= valid_if_d;
            fetch_count <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_data_if.sv
// Directed bench for data_if: reset state, sequential fetch, stall, redirect,
// stall-over-branch priority, asynchronous reset and PC wrap-around.
module tb_data_if;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        BRsignal;
    logic [63:0] BR_to_shift;
    logic [63:0] pc_id;

    logic [31:0] instr_mem;
    logic [63:0] imem_addr;
    logic [63:0] pc_if;
    logic [31:0] instr_if;
    logic [63:0] BLT;
    logic        valid_if;
    logic [31:0] fetch_count;

    logic [31:0] w_instr_mem;
    logic [63:0] w_imem_addr;
    logic [63:0] w_pc_if;
    logic [31:0] w_instr_if;
    logic [63:0] w_BLT;
    logic        w_valid_if;
    logic [31:0] w_fetch_count;

    localparam logic [31:0] NOP = 32'hD503201F;

    int checks;
    int failures;

    // Instruction memory model: word at address A reads as 0x1000 + A.
    assign instr_mem   = 32'h1000 + imem_addr[31:0];
    assign w_instr_mem = 32'h1000 + w_imem_addr[31:0];

    data_if dut (
        .clk(clk), .reset(reset), .stall(stall), .BRsignal(BRsignal),
        .BR_to_shift(BR_to_shift), .pc_id(pc_id), .instr_mem(instr_mem),
        .imem_addr(imem_addr), .pc_if(pc_if), .instr_if(instr_if),
        .BLT(BLT), .valid_if(valid_if), .fetch_count(fetch_count)
    );

    data_if #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .stall(stall), .BRsignal(BRsignal),
        .BR_to_shift(BR_to_shift), .pc_id(pc_id), .instr_mem(w_instr_mem),
        .imem_addr(w_imem_addr), .pc_if(w_pc_if), .instr_if(w_instr_if),
        .BLT(w_BLT), .valid_if(w_valid_if), .fetch_count(w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        br;
        logic [63:0] shift;
        logic [63:0] pcid;
        logic [63:0] addr;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] blt;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] addr, input logic [63:0] pc,
                             input logic [31:0] instr, input logic [63:0] blt,
                             input logic valid, input logic [31:0] cnt);
        check({tag, ".imem_addr"}, imem_addr, addr);
        check({tag, ".pc_if"}, pc_if, pc);
        check({tag, ".instr_if"}, {32'h0, instr_if}, {32'h0, instr});
        check({tag, ".BLT"}, BLT, blt);
        check({tag, ".valid_if"}, {63'h0, valid_if}, {63'h0, valid});
        check({tag, ".fetch_count"}, {32'h0, fetch_count}, {32'h0, cnt});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        BRsignal    = 1'b0;
        BR_to_shift = 64'h0;
        pc_id       = 64'h0;

        //            name        st  br  shift                   pc_id    addr     pc_if    instr        BLT      v  cnt
        vecs[0]  = '{"adv2",      0,  0,  64'h0,                  64'h0,   64'h8,   64'h4,   32'h1004,    64'h8,   1, 2};
        vecs[1]  = '{"stall1",    1,  0,  64'h0,                  64'h0,   64'h8,   64'h4,   32'h1004,    64'h8,   1, 2};
        vecs[2]  = '{"stall2",    1,  0,  64'h0,                  64'h0,   64'h8,   64'h4,   32'h1004,    64'h8,   1, 2};
        vecs[3]  = '{"unstall",   0,  0,  64'h0,                  64'h0,   64'hC,   64'h8,   32'h1008,    64'hC,   1, 3};
        vecs[4]  = '{"br_back",   0,  1,  64'hFFFF_FFFF_FFFF_FFFE, 64'h10, 64'h8,   64'h8,   NOP,         64'hC,   0, 3};
        vecs[5]  = '{"br_tgt",    0,  0,  64'h0,                  64'h0,   64'hC,   64'h8,   32'h1008,    64'hC,   1, 4};
        vecs[6]  = '{"st_br",     1,  1,  64'h4,                  64'h100, 64'hC,   64'h8,   32'h1008,    64'hC,   1, 4};
        vecs[7]  = '{"br_fwd",    0,  1,  64'h4,                  64'h100, 64'h110, 64'h8,   NOP,         64'hC,   0, 4};
        vecs[8]  = '{"fwd_tgt",   0,  0,  64'h0,                  64'h0,   64'h114, 64'h110, 32'h1110,    64'h114, 1, 5};
        vecs[9]  = '{"br_trunc",  0,  1,  64'h4000_0000_0000_0001, 64'h4,  64'h8,   64'h110, NOP,         64'h114, 0, 5};
        vecs[10] = '{"trunc_tgt", 0,  0,  64'h0,                  64'h0,   64'hC,   64'h8,   32'h1008,    64'hC,   1, 6};

        step();
        step();
        check_all("reset", 64'h0, 64'h0, NOP, 64'h0, 1'b0, 32'h0);
        check("wrap.reset_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // First edge out of reset: both instances advance once.
        reset = 1'b0;
        step();
        check_all("adv1", 64'h4, 64'h0, 32'h1000, 64'h4, 1'b1, 32'h1);
        check("wrap.imem_addr", w_imem_addr, 64'h0);
        check("wrap.pc_if", w_pc_if, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap.BLT", w_BLT, 64'h0);
        check("wrap.instr_if", {32'h0, w_instr_if}, 64'h0000_0FFC);

        for (int i = 0; i < 11; i++) begin
            stall       = vecs[i].stall;
            BRsignal    = vecs[i].br;
            BR_to_shift = vecs[i].shift;
            pc_id       = vecs[i].pcid;
            step();
            check_all(vecs[i].name, vecs[i].addr, vecs[i].pc, vecs[i].instr,
                      vecs[i].blt, vecs[i].valid, vecs[i].cnt);
        end

        // Reset between edges while a stall and a branch are both pending.
        stall       = 1'b1;
        BRsignal    = 1'b1;
        BR_to_shift = 64'h40;
        pc_id       = 64'h0;
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 64'h0, 64'h0, NOP, 64'h0, 1'b0, 32'h0);
        step();
        reset    = 1'b0;
        stall    = 1'b0;
        BRsignal = 1'b0;
        step();
        check_all("post_rst", 64'h4, 64'h0, 32'h1000, 64'h4, 1'b1, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
